// File: rtl/i2c_passthru_bus_recovery.sv
// i2c_passthru_bus_recovery
//   Bus-recovery sequencer for the I2C passthru. Once the stuck detector
//   flags the bus, this block drives SCL through an open-drain pull-down.
//   It clocks up to N_PULSES pulses per attempt, stopping early once the
//   target releases SDA. It can optionally issue a STOP, and then checks
//   that the bus is free. A failed check starts another attempt, up to
//   N_ATTEMPTS in total, before the block declares failure.
//
//   Optional build macro: I2C_PASSTHRU_RECOVERY_STOP_EN
//     defined   : a STOP (SDA low -> SCL high -> SDA high) follows the pulses
//     undefined : the STOP states are not built and o_sda_low is tied 0
//
// Ports
//   i_clk, i_rstn  system clock, synchronous active-low reset
//   i_f_ref        slow reference square wave; its rising edge is the timer tick
//   i_en           recovery enable; low aborts any sequence
//   i_stuck        stuck flag from the idle/stuck detector
//   i_idle         idle flag from the idle/stuck detector
//   i_sda, i_scl   synchronized bus levels
//   o_scl_low      1 = pull SCL low
//   o_sda_low      1 = pull SDA low
//   o_busy         sequence in progress (not idle, not failed)
//   o_done         1-cycle pulse on a successful recovery
//   o_fail         high while parked in the failed state
//   o_attempts     attempts made in the current or most recent recovery
module i2c_passthru_bus_recovery #(
    parameter int F_REF_T_HALF       = 38,
    parameter int WIDTH_F_REF_T_HALF = 6,
    parameter int N_PULSES           = 9,
    parameter int WIDTH_PULSES       = 4,
    parameter int N_ATTEMPTS         = 3,
    parameter int WIDTH_ATTEMPTS     = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_f_ref,
    input  logic                      i_en,
    input  logic                      i_stuck,
    input  logic                      i_idle,
    input  logic                      i_sda,
    input  logic                      i_scl,
    output logic                      o_scl_low,
    output logic                      o_sda_low,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_fail,
    output logic [WIDTH_ATTEMPTS-1:0] o_attempts
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOW, ST_HIGH, ST_STOP_A, ST_STOP_B, ST_STOP_C, ST_CHECK, ST_FAIL
    } state_t;

    localparam logic [WIDTH_F_REF_T_HALF-1:0] T_LOAD = WIDTH_F_REF_T_HALF'(F_REF_T_HALF);
    localparam logic [WIDTH_PULSES-1:0]       P_MAX  = WIDTH_PULSES'(N_PULSES);
    localparam logic [WIDTH_ATTEMPTS-1:0]     A_MAX  = WIDTH_ATTEMPTS'(N_ATTEMPTS);

    state_t                        state, state_nxt;
    logic [WIDTH_F_REF_T_HALF-1:0] timer, timer_nxt, timer_dec;
    logic [WIDTH_PULSES-1:0]       pulse_cnt, pulse_nxt, pulse_inc;
    logic [WIDTH_ATTEMPTS-1:0]     attempts, att_nxt;
    logic                          done_nxt;
    logic                          f_ref_q, tick;

    // Reference edge detector. A missed first tick after reset only
    // lengthens one phase by at most a tick period, so it is left unreset.
    always_ff @(posedge i_clk) f_ref_q <= i_f_ref;
    assign tick = i_f_ref & ~f_ref_q;

    assign timer_dec = (tick && timer != '0) ? timer - 1'b1 : timer;
    assign pulse_inc = (pulse_cnt == P_MAX) ? pulse_cnt : pulse_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pulse_nxt = pulse_cnt;
        att_nxt   = attempts;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_en && i_stuck) begin
                    state_nxt = ST_LOW;
                    pulse_nxt = '0;
                    att_nxt   = WIDTH_ATTEMPTS'(1);
                end else if (i_idle) begin
                    att_nxt = '0;
                end
            end
            ST_LOW: begin
                if (timer == '0) state_nxt = ST_HIGH;
                else             timer_nxt = timer_dec;
            end
            ST_HIGH: begin
                // Target holding SCL low stretches the high phase.
                if (!i_scl) begin
                    timer_nxt = T_LOAD;
                end else if (timer == '0) begin
                    pulse_nxt = pulse_inc;
                    if (i_sda || pulse_inc == P_MAX) begin
`ifdef I2C_PASSTHRU_RECOVERY_STOP_EN
                        state_nxt = ST_STOP_A;
`else
                        state_nxt = ST_CHECK;
`endif
                    end else begin
                        state_nxt = ST_LOW;
                    end
                end else begin
                    timer_nxt = timer_dec;
                end
            end
`ifdef I2C_PASSTHRU_RECOVERY_STOP_EN
            ST_STOP_A: begin
                if (timer == '0) state_nxt = ST_STOP_B;
                else             timer_nxt = timer_dec;
            end
            ST_STOP_B: begin
                if (!i_scl)              timer_nxt = T_LOAD;
                else if (timer == '0)    state_nxt = ST_STOP_C;
                else                     timer_nxt = timer_dec;
            end
            ST_STOP_C: begin
                if (timer == '0) state_nxt = ST_CHECK;
                else             timer_nxt = timer_dec;
            end
`endif
            ST_CHECK: begin
                if (i_sda && i_scl) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (attempts == A_MAX) begin
                    state_nxt = ST_FAIL;
                end else begin
                    att_nxt   = attempts + 1'b1;
                    pulse_nxt = '0;
                    state_nxt = ST_LOW;
                end
            end
            ST_FAIL: begin
                if (!i_stuck) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Disable beats every other transition, including a same-cycle expiry.
        if (!i_en) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
            if (state != ST_IDLE) begin
                att_nxt   = attempts;
                pulse_nxt = pulse_cnt;
            end
        end

        if (state_nxt != state) timer_nxt = T_LOAD;
    end

    // Pull enables are decoded from the next state and registered, so they
    // change exactly on state entry and cannot glitch.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= ST_IDLE;
            timer     <= '0;
            pulse_cnt <= '0;
            attempts  <= '0;
            o_scl_low <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_fail    <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            pulse_cnt <= pulse_nxt;
            attempts  <= att_nxt;
            o_scl_low <= (state_nxt == ST_LOW) || (state_nxt == ST_STOP_A);
            o_busy    <= (state_nxt != ST_IDLE) && (state_nxt != ST_FAIL);
            o_done    <= done_nxt;
            o_fail    <= (state_nxt == ST_FAIL);
        end
    end

`ifdef I2C_PASSTHRU_RECOVERY_STOP_EN
    always_ff @(posedge i_clk) begin
        if (!i_rstn) o_sda_low <= 1'b0;
        else         o_sda_low <= (state_nxt == ST_STOP_A) || (state_nxt == ST_STOP_B);
    end
`else
    assign o_sda_low = 1'b0;
`endif

    assign o_attempts = attempts;

endmodule

// File: tb/tb_i2c_passthru_bus_recovery.sv
// Bench for i2c_passthru_bus_recovery. A procedural model walks through
// the recovery sequence (attempt -> pulses -> optional STOP -> check) and
// publishes the expected outputs. A negedge process compares every output
// on every cycle. Directed scenarios add literal pulse/STOP/done counts,
// and randomized runs vary the target release point, the stretching and
// the aborts.
module tb_i2c_passthru_bus_recovery;
    localparam int F  = 4;
    localparam int WF = 3;
    localparam int NP = 9;
    localparam int WP = 4;
    localparam int NA = 3;
    localparam int WA = 2;
`ifdef I2C_PASSTHRU_RECOVERY_STOP_EN
    localparam int STOP_ON = 1;
`else
    localparam int STOP_ON = 0;
`endif

    logic i_clk = 0, i_rstn = 0, i_f_ref = 0, i_en = 0, i_stuck = 0, i_idle = 0;
    logic i_sda, i_scl;
    logic o_scl_low, o_sda_low, o_busy, o_done, o_fail;
    logic [WA-1:0] o_attempts;

    // open-drain bus: target can stretch SCL and hold SDA
    logic stretch = 0, tgt_low = 0;
    assign i_scl = ~(o_scl_low | stretch);
    assign i_sda = ~(o_sda_low | tgt_low);

    i2c_passthru_bus_recovery #(
        .F_REF_T_HALF(F), .WIDTH_F_REF_T_HALF(WF), .N_PULSES(NP),
        .WIDTH_PULSES(WP), .N_ATTEMPTS(NA), .WIDTH_ATTEMPTS(WA)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_f_ref(i_f_ref), .i_en(i_en),
        .i_stuck(i_stuck), .i_idle(i_idle), .i_sda(i_sda), .i_scl(i_scl),
        .o_scl_low(o_scl_low), .o_sda_low(o_sda_low), .o_busy(o_busy),
        .o_done(o_done), .o_fail(o_fail), .o_attempts(o_attempts)
    );

    always #5 i_clk = ~i_clk;

    initial forever begin
        repeat ($urandom_range(1, 3)) @(posedge i_clk);
        #1 i_f_ref = ~i_f_ref;
    end

    int n_chk = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- target model ----------------
    int rise_cnt = 0, release_after = 0, fall_cnt = 0, stretch_at = 0, stretch_len = 0;
    int stretch_left = 0;
    logic scl_prev = 1, sclo_prev = 0;
    always @(posedge i_clk) begin
        logic scl_now;
        #2;
        if (!o_scl_low && sclo_prev && !o_sda_low) begin
            fall_cnt++;
            if (fall_cnt == stretch_at) stretch_left = stretch_len;
        end
        sclo_prev = o_scl_low;
        stretch = (stretch_left > 0);
        if (stretch_left > 0) stretch_left--;
        scl_now = !(o_scl_low || stretch);
        if (scl_now && !scl_prev) rise_cnt++;
        scl_prev = scl_now;
        tgt_low = (rise_cnt < release_after);
    end

    // ---------------- behavioural model ----------------
    logic e_scl = 0, e_sda = 0, e_busy = 0, e_done = 0, e_fail = 0;
    logic [WA-1:0] e_att = 0;
    logic s_rstn, s_en, s_stuck, s_idle, s_sda, s_scl, s_tick;
    logic m_fprev = 0;

    task automatic m_edge();
        @(posedge i_clk);
        s_rstn = i_rstn; s_en = i_en; s_stuck = i_stuck; s_idle = i_idle;
        s_sda = i_sda;   s_scl = i_scl;
        s_tick = i_f_ref && !m_fprev;
        m_fprev = i_f_ref;
    endtask

    function automatic bit m_abort();
        if (!s_rstn || !s_en) begin
            e_scl = 0; e_sda = 0; e_busy = 0; e_done = 0; e_fail = 0;
            if (!s_rstn) e_att = 0;
            return 1;
        end
        return 0;
    endfunction

    // One timed phase: hold the given pulls for F ticks (stretch restarts the count).
    task automatic m_phase(input bit scl, input bit sda, input bit stretchable, output bit ok);
        int t = F;
        e_scl = scl; e_sda = sda; e_busy = 1; e_done = 0; e_fail = 0;
        forever begin
            m_edge();
            if (m_abort()) begin ok = 0; return; end
            if (stretchable && !s_scl) t = F;
            else if (t == 0) begin ok = 1; return; end
            else if (s_tick) t--;
        end
    endtask

    task automatic m_recover();
        bit ok;
        int p;
        for (int att = 1; att <= NA; att++) begin
            e_att = WA'(att);
            p = 0;
            forever begin
                m_phase(1, 0, 0, ok); if (!ok) return;
                m_phase(0, 0, 1, ok); if (!ok) return;
                p++;
                if (s_sda || p == NP) break;
            end
            if (STOP_ON != 0) begin
                m_phase(1, 1, 0, ok); if (!ok) return;
                m_phase(0, 1, 1, ok); if (!ok) return;
                m_phase(0, 0, 0, ok); if (!ok) return;
            end
            e_scl = 0; e_sda = 0; e_busy = 1; e_done = 0; e_fail = 0;
            m_edge();
            if (m_abort()) return;
            if (s_sda && s_scl) begin e_busy = 0; e_done = 1; return; end
            if (att == NA) begin
                e_busy = 0; e_fail = 1;
                forever begin
                    m_edge();
                    if (m_abort()) return;
                    if (!s_stuck) begin e_fail = 0; return; end
                end
            end
        end
    endtask

    initial forever begin
        m_edge();
        if (!m_abort() || s_rstn) begin
            e_scl = 0; e_sda = 0; e_busy = 0; e_done = 0; e_fail = 0;
            if (!s_rstn) e_att = 0;
            else if (s_en && s_stuck) begin
                e_att = 1;
                m_recover();
            end else if (s_idle) e_att = 0;
        end
    end

    // ---------------- compare + monitor ----------------
    bit chk_on = 0;
    int pulses = 0, stops = 0, dones = 0, fails_seen = 0, mon_fall = 0, hp2_len = 0;
    logic p_scl = 0, p_sda = 0;
    always @(negedge i_clk) if (chk_on) begin
        check("scl_low", o_scl_low, e_scl);
        check("sda_low", o_sda_low, e_sda);
        check("busy", o_busy, e_busy);
        check("done", o_done, e_done);
        check("fail", o_fail, e_fail);
        check("attempts", o_attempts, e_att);
        if (o_scl_low && !p_scl && !o_sda_low) pulses++;
        if (!o_scl_low && p_scl && !o_sda_low) mon_fall++;
        if (o_sda_low && !p_sda) stops++;
        if (o_done) dones++;
        if (o_fail) fails_seen++;
        if (mon_fall == 2 && !o_scl_low && o_busy) hp2_len++;
        p_scl = o_scl_low;
        p_sda = o_sda_low;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask
    task automatic clear_stats();
        pulses = 0; stops = 0; dones = 0; fails_seen = 0; mon_fall = 0; hp2_len = 0;
        rise_cnt = 0; fall_cnt = 0;
    endtask
    task automatic wait_quiet(input int budget, input string name);
        int n = 0;
        while ((o_busy || o_fail) && n < budget) begin cyc(1); n++; end
        if (o_busy || o_fail) timeout(name);
    endtask

    initial begin
        cyc(1);
        chk_on = 1;
        cyc(2);
        check("rst_busy", o_busy, 0);
        check("rst_att", o_attempts, 0);
        check("rst_scl", o_scl_low, 0);
        i_rstn = 1; i_en = 1;
        cyc(2);

        // 1: target releases SDA at the 3rd high phase
        clear_stats(); release_after = 3; stretch_at = 0;
        i_stuck = 1; cyc(1);
        check("start_lat", o_scl_low, 1);
        i_stuck = 0;
        wait_quiet(3000, "s1_wait");
        cyc(2);
        check("s1_pulses", pulses, 3);
        check("s1_stops", stops, STOP_ON);
        check("s1_done", dones, 1);
        check("s1_att", o_attempts, 1);
        i_idle = 1; cyc(2); i_idle = 0;
        check("s1_att_clr", o_attempts, 0);

        // 2: SDA stuck forever -> fail after all attempts
        clear_stats(); release_after = 100000;
        i_stuck = 1;
        begin
            int n = 0;
            while (!o_fail && n < 20000) begin cyc(1); n++; end
            if (!o_fail) timeout("s2_wait_fail");
        end
        cyc(3);
        check("s2_pulses", pulses, NP * NA);
        check("s2_stops", stops, STOP_ON * NA);
        check("s2_fail", o_fail, 1);
        check("s2_pulls", {o_scl_low, o_sda_low}, 0);
        check("s2_att", o_attempts, NA);
        i_stuck = 0; cyc(2);
        check("s2_fail_clr", o_fail, 0);
        release_after = 0; cyc(2);

        // 3: stretch during the 2nd high phase
        clear_stats(); release_after = 3; stretch_at = 2; stretch_len = 100;
        i_stuck = 1; cyc(1); i_stuck = 0;
        wait_quiet(5000, "s3_wait");
        cyc(2);
        check("s3_pulses", pulses, 3);
        check("s3_done", dones, 1);
        check("s3_hp2_ge", hp2_len >= 100 + F, 1);
        stretch_at = 0;

        // 4: disable in the middle of the low phase
        clear_stats(); release_after = 100000;
        i_stuck = 1; cyc(3);
        check("s4_in_low", o_scl_low, 1);
        i_en = 0; cyc(1);
        check("s4_scl", o_scl_low, 0);
        check("s4_busy", o_busy, 0);
        i_stuck = 0; cyc(3);
        check("s4_no_done", dones, 0);
        check("s4_no_fail", fails_seen, 0);
        release_after = 0; i_en = 1; cyc(2);

        // 6: reset in STOP_A (or in the low phase when STOP is not built)
        clear_stats(); release_after = 1;
        i_stuck = 1; cyc(1); i_stuck = 0;
        begin
            int n = 0;
            while (!(STOP_ON != 0 ? o_sda_low : o_scl_low) && n < 2000) begin cyc(1); n++; end
            if (!(STOP_ON != 0 ? o_sda_low : o_scl_low)) timeout("s6_wait");
        end
        i_rstn = 0; cyc(1);
        check("s6_outs", {o_scl_low, o_sda_low, o_busy, o_done, o_fail}, 0);
        check("s6_att", o_attempts, 0);
        cyc(1); i_rstn = 1; cyc(2);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            int drop_at, k;
            clear_stats();
            release_after = $urandom_range(1, 20);
            stretch_at    = $urandom_range(0, 4);
            stretch_len   = $urandom_range(5, 40);
            drop_at       = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 300) : -1;
            i_stuck = 1;
            cyc($urandom_range(1, 3));
            i_stuck = 0;
            k = 0;
            while ((o_busy || o_fail) && k < 20000) begin
                cyc(1); k++;
                if (k == drop_at) i_en = 0;
            end
            if (o_busy || o_fail) timeout("rand_wait");
            cyc(2);
            release_after = 0; stretch_at = 0; i_en = 1;
            i_idle = 1'($urandom_range(0, 1));
            cyc(3);
            i_idle = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
